// File: rtl/memory_ctrl_v2.sv
// memory_ctrl_v2
//   Sequential segment controller between the load/store unit and the
//   segment memories. Takes one single-beat read/write request at a time over
//   a valid/ready handshake, decodes the word address into one of NUM_SEG
//   segments (segment 0 at the top of the address space), drives one-hot mux
//   selects plus the segment write strobe, waits READ_LAT cycles for reads,
//   and returns a one-cycle response with a bus-error flag.
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready request handshake
//   req_wr              1 = write, 0 = read
//   req_addr            word address
//   req_wdata           write data
//   resp_valid          one-cycle response pulse
//   resp_rdata          read data (0 for writes and errors)
//   resp_err            unmapped address or protected write
//   sel_mux_data_in     one-hot write-path select (WRITE state only)
//   sel_mux_data_out    one-hot read-path select (READ state only)
//   seg_we              segment write strobe
//   seg_addr            offset within the segment
//   seg_wdata           registered write data
//   seg_rdata           flattened read data, segment k at [k*DATA_W +: DATA_W]
module memory_ctrl_v2 #(
  parameter int                     DATA_W   = 32,
  parameter int                     ADDR_W   = 10,
  parameter int                     NUM_SEG  = 5,
  parameter int                     SEG_LOG2 = 7,
  parameter int                     READ_LAT = 2,
  parameter logic [NUM_SEG-1:0]     WP_MASK  = 5'b00001
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_wr,
  input  logic [ADDR_W-1:0]         req_addr,
  input  logic [DATA_W-1:0]         req_wdata,
  output logic                      resp_valid,
  output logic [DATA_W-1:0]         resp_rdata,
  output logic                      resp_err,
  output logic [NUM_SEG-1:0]        sel_mux_data_in,
  output logic [NUM_SEG-1:0]        sel_mux_data_out,
  output logic                      seg_we,
  output logic [SEG_LOG2-1:0]       seg_addr,
  output logic [DATA_W-1:0]         seg_wdata,
  input  logic [NUM_SEG*DATA_W-1:0] seg_rdata
);

  localparam int SEG_W = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1;
  localparam int CNT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam int TOP_W = ADDR_W - SEG_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_RESP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [SEG_W-1:0]   seg_q;

  // Segments are counted downward from the top of the address space, so the
  // segment index is the upper address bits measured from the top:
  // (2**ADDR_W-1 - addr) >> SEG_LOG2 == ~addr[ADDR_W-1:SEG_LOG2].
  logic [TOP_W-1:0]   top_idx;
  logic               dec_mapped;
  logic [SEG_W-1:0]   dec_seg;
  logic [NUM_SEG-1:0] dec_oh;
  logic               dec_err;

  assign top_idx    = ~req_addr[ADDR_W-1:SEG_LOG2];
  assign dec_mapped = (32'(top_idx) < 32'(NUM_SEG));
  assign dec_seg    = SEG_W'(top_idx);
  assign dec_oh     = NUM_SEG'(1) << dec_seg;
  assign dec_err    = !dec_mapped || (req_wr && WP_MASK[dec_seg]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= S_IDLE;
      cnt              <= '0;
      seg_q            <= '0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_err         <= 1'b0;
      sel_mux_data_in  <= '0;
      sel_mux_data_out <= '0;
      seg_we           <= 1'b0;
      seg_addr         <= '0;
      seg_wdata        <= '0;
    end else begin
      case (state)
        // IDLE: accept, latch and decode
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            seg_q     <= dec_seg;
            seg_addr  <= req_addr[SEG_LOG2-1:0];
            seg_wdata <= req_wdata;
            if (dec_err) begin
              // Error path never touches the segment selects or strobe.
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else if (req_wr) begin
              state           <= S_WRITE;
              seg_we          <= 1'b1;
              sel_mux_data_in <= dec_oh;
            end else begin
              state            <= S_READ;
              sel_mux_data_out <= dec_oh;
              cnt              <= CNT_W'(READ_LAT - 1);
            end
          end
        end
        // WRITE: single strobe cycle
        S_WRITE: begin
          state           <= S_RESP;
          seg_we          <= 1'b0;
          sel_mux_data_in <= '0;
          resp_valid      <= 1'b1;
          resp_err        <= 1'b0;
          resp_rdata      <= '0;
        end
        // READ: hold the select for READ_LAT cycles, capture on the last one
        S_READ: begin
          if (cnt == '0) begin
            state            <= S_RESP;
            sel_mux_data_out <= '0;
            resp_valid       <= 1'b1;
            resp_err         <= 1'b0;
            resp_rdata       <= seg_rdata[seg_q*DATA_W +: DATA_W];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // RESP: one-cycle response, then ready again
        S_RESP: begin
          state      <= S_IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/memory_ctrl_v2.md
# memory_ctrl_v2

Parametrised, sequential successor to the first-generation segment decoder. It accepts single-beat read/write requests over a valid/ready handshake and decodes the address into one of `NUM_SEG` memory segments, with segment 0 at the top of the address space. It drives one-hot data-in/data-out mux selects and the segment write strobe, waits a configurable read latency, and returns a single-cycle response with a bus-error flag. It sits between the core's load/store unit and the segment memories.

## Interface
Parameters:
- `DATA_W`, 32, data width.
- `ADDR_W`, 10, word-address width.
- `NUM_SEG`, 5, number of segments; width of the select buses.
- `SEG_LOG2`, 7, log2 of segment size in words. `NUM_SEG << SEG_LOG2` must not exceed `2**ADDR_W`.
- `READ_LAT`, 2, segment read latency in cycles; must be ≥ 1.
- `WP_MASK`, 5'b00001, per-segment write-protect mask; bit k set means segment k is read-only.

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller can accept a request.
- `req_wr` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_W`: word address.
- `req_wdata` in `DATA_W`: write data.
- `resp_valid` out 1: one-cycle response pulse.
- `resp_rdata` out `DATA_W`: read data; 0 for writes and errors.
- `resp_err` out 1: unmapped address or protected write.
- `sel_mux_data_in` out `NUM_SEG`: one-hot write-path select.
- `sel_mux_data_out` out `NUM_SEG`: one-hot read-path select.
- `seg_we` out 1: write strobe to the selected segment.
- `seg_addr` out `SEG_LOG2`: offset within the segment.
- `seg_wdata` out `DATA_W`: registered write data.
- `seg_rdata` in `NUM_SEG*DATA_W`: flattened read data; segment k occupies bits `[k*DATA_W +: DATA_W]`.

## Operation
- **Address decode.** Segment k covers `[2**ADDR_W-(k+1)*2**SEG_LOG2, 2**ADDR_W-k*2**SEG_LOG2-1]`. Default map: seg0 = 0x380–0x3FF, seg4 = 0x180–0x1FF. Addresses below the lowest segment are unmapped.
- **Segment offset.** `seg_addr` = `req_addr[SEG_LOG2-1:0]` captured at accept.
- **FSM states.** IDLE, WRITE, READ, RESP.
- **IDLE.** `req_ready`=1. On `req_valid`, the controller latches wr/addr/wdata and decodes the segment:
  - unmapped address, or write to a segment with its `WP_MASK` bit set → RESP with error;
  - write → WRITE;
  - read → READ with the latency counter at `READ_LAT-1`.
- **WRITE.** Lasts 1 cycle. `seg_we`=1 and `sel_mux_data_in` = one-hot of the segment. Next state is RESP.
- **READ.** `sel_mux_data_out` is held at the one-hot of the segment, and the counter decrements.
  - When the counter reaches 0, the selected slice of `seg_rdata` is captured into the response register and the FSM moves to RESP.
  - Total READ dwell is exactly `READ_LAT` cycles.
- **RESP.** Lasts 1 cycle. `resp_valid`=1, with `resp_err`/`resp_rdata` valid. Next state is IDLE. There is no response backpressure.
- **Outputs outside their states.** Selects and `seg_we` are 0 outside WRITE/READ. `req_ready`=0 outside IDLE. Requests presented while busy are not accepted and the requester must hold them.
- **Error responses.** Never assert `seg_we` or any select bit. `resp_rdata`=0.

## Timing
- **Reset values.** While `rst`=0: state IDLE, `req_ready`=1, and every other output is 0, including `seg_addr` and `seg_wdata`.
- **Reset mid-operation.** An asynchronous reset mid-operation aborts immediately: no `seg_we` pulse and no response are produced.
- **Write latency.** Accept in cycle 0; `seg_we` in cycle 1; `resp_valid` in cycle 2; `req_ready` in cycle 3. Three cycles per transaction.
- **Read latency.** Accept in cycle 0; selects in cycles 1..`READ_LAT`; `resp_valid` in cycle `READ_LAT+1`; next accept in cycle `READ_LAT+2` at the earliest.
- **Error latency.** Accept in cycle 0; `resp_valid` with `resp_err`=1 in cycle 1; `req_ready` in cycle 2.
- **Response fields.** `resp_rdata` and `resp_err` are registered and stable for the whole `resp_valid` cycle; both are 0 whenever `resp_valid`=0.
- **Boundary addresses.** 0x3FF → seg0, offset 0x7F. 0x380 → seg0. 0x37F → seg1. 0x180 → seg4, offset 0. 0x17F → unmapped.
- **One-hot invariant.** At most one bit of each select bus is set, and the two buses are never non-zero in the same cycle.

## Test plan
- **Reset values.** Assert `rst`=0 mid-READ → all outputs 0 and `req_ready`=1 asynchronously; after release, an idle cycle produces no spurious `resp_valid`.
- **Write to seg1.** Write 0x25 to 0x37F → cycle 1: `seg_we`=1, `sel_mux_data_in`=5'b00010, `seg_addr`=0x7F, `seg_wdata`=0x25; cycle 2: `resp_valid`=1, `resp_err`=0.
- **Read from seg2.** Read 0x2A0 with `READ_LAT`=2 and the seg2 slice = 0xDEADBEEF → `sel_mux_data_out`=5'b00100 for 2 cycles; cycle 3: `resp_rdata`=0xDEADBEEF.
- **Protected write.** Write to 0x3FF (seg0, protected) → cycle 1: `resp_valid`=1, `resp_err`=1; `seg_we` never asserts.
- **Unmapped read.** Read 0x000 → error response in cycle 1 with `resp_rdata`=0. Read 0x180 → seg4 select, no error.
- **Back-to-back requests.** Hold `req_valid` continuously for write then read → second accept only when `req_ready` returns (cycle 3); the one-hot invariant holds throughout.
